// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: bus master for the uart_regs register port.
// Configures divisor/LCR/FCR/IER on request, then services the UART by
// polling LSR, feeding THR from a TX byte stream and draining RB into an
// RX byte stream through a one-entry holding register.
module uart_host_ctrl #(
  parameter int         FIFO_DEPTH = 16,
  parameter int         SETTLE     = 3,
  parameter logic [7:0] FCR_INIT   = 8'hC6
) (
  input  logic        clk,
  input  logic        wb_rst_ni,
  input  logic        cfg_start_i,
  input  logic [15:0] cfg_div_i,
  input  logic [6:0]  cfg_lcr_i,
  output logic        cfg_done_o,
  output logic        cfg_err_o,
  output logic [2:0]  uart_addr_o,
  output logic [7:0]  uart_dat_o,
  output logic        uart_we_o,
  output logic        uart_re_o,
  input  logic [7:0]  uart_dat_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [4:0]  rx_err_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  localparam logic [2:0] A_RB  = 3'd0;
  localparam logic [2:0] A_IE  = 3'd1;
  localparam logic [2:0] A_FC  = 3'd2;
  localparam logic [2:0] A_LC  = 3'd3;
  localparam logic [2:0] A_LS  = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, C_LCRD, C_DLL, C_DLM, C_LCR, C_FCR, C_IER,
    S_WAIT, S_POLL, S_DECIDE, S_RD, S_WR
  } state_t;

  state_t         state;
  logic [15:0]    div_q;
  logic [6:0]     lcr_q;
  logic [7:0]     lsr_q;
  logic [CW-1:0]  credit;
  logic [SW-1:0]  wcnt;
  logic           cfg_go;
  logic           bus_idle;

  assign cfg_go   = cfg_start_i && (cfg_div_i != 16'd0);
  assign bus_idle = !uart_we_o && !uart_re_o;

  // A byte is taken only in WR with credit left; a restarting configuration
  // refuses it so the registered write slot is not lost to the LC write.
  assign tx_ready_o = (state == S_WR) && tx_valid_i && (credit != '0) && !cfg_go;

  // Main FSM: registered bus strobes are loaded together with the next state,
  // so each state's access is on the bus during the cycle the FSM sits there.
  // Accepted TX bytes appear on the bus the cycle after the handshake.
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= S_IDLE;
      div_q       <= '0;
      lcr_q       <= '0;
      lsr_q       <= '0;
      credit      <= '0;
      wcnt        <= '0;
      cfg_done_o  <= 1'b0;
      cfg_err_o   <= 1'b0;
      uart_addr_o <= '0;
      uart_dat_o  <= '0;
      uart_we_o   <= 1'b0;
      uart_re_o   <= 1'b0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      rx_err_o    <= '0;
    end else begin
      uart_we_o   <= 1'b0;
      uart_re_o   <= 1'b0;
      uart_addr_o <= '0;
      uart_dat_o  <= '0;

      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
      // RD is only entered with the holding register empty, so no overwrite.
      if (state == S_RD) begin
        rx_data_o  <= uart_dat_i;
        rx_valid_o <= 1'b1;
      end

      if (cfg_start_i && (cfg_div_i == 16'd0)) cfg_err_o <= 1'b1;

      if (cfg_go) begin
        div_q       <= cfg_div_i;
        lcr_q       <= cfg_lcr_i;
        cfg_err_o   <= 1'b0;
        cfg_done_o  <= 1'b0;
        rx_err_o    <= '0;
        credit      <= '0;
        state       <= C_LCRD;
        uart_we_o   <= 1'b1;
        uart_addr_o <= A_LC;
        uart_dat_o  <= {1'b1, cfg_lcr_i};
      end else begin
        case (state)
          S_IDLE: state <= S_IDLE;
          C_LCRD: begin
            state <= C_DLL;
            uart_we_o <= 1'b1; uart_addr_o <= A_RB; uart_dat_o <= div_q[7:0];
          end
          C_DLL: begin
            state <= C_DLM;
            uart_we_o <= 1'b1; uart_addr_o <= A_IE; uart_dat_o <= div_q[15:8];
          end
          C_DLM: begin
            state <= C_LCR;
            uart_we_o <= 1'b1; uart_addr_o <= A_LC; uart_dat_o <= {1'b0, lcr_q};
          end
          C_LCR: begin
            state <= C_FCR;
            uart_we_o <= 1'b1; uart_addr_o <= A_FC; uart_dat_o <= FCR_INIT;
          end
          C_FCR: begin
            state <= C_IER;
            uart_we_o <= 1'b1; uart_addr_o <= A_IE; uart_dat_o <= 8'h00;
          end
          C_IER: begin
            state      <= S_WAIT;
            wcnt       <= '0;
            cfg_done_o <= 1'b1;
          end
          // Count only cycles with a quiet bus, so a trailing THR write
          // does not eat into the settle time before the next LSR read.
          S_WAIT: begin
            if (bus_idle) begin
              if (wcnt == SW'(SETTLE - 1)) begin
                state <= S_POLL;
                uart_re_o <= 1'b1; uart_addr_o <= A_LS;
              end else begin
                wcnt <= wcnt + 1'b1;
              end
            end
          end
          S_POLL: begin
            lsr_q    <= uart_dat_i;
            rx_err_o <= rx_err_o | {uart_dat_i[7], uart_dat_i[4:1]};
            if (uart_dat_i[5]) credit <= CW'(FIFO_DEPTH);
            state    <= S_DECIDE;
          end
          S_DECIDE: begin
            if (lsr_q[0] && !rx_valid_o) begin
              state <= S_RD;
              uart_re_o <= 1'b1; uart_addr_o <= A_RB;
            end else if (tx_valid_i && (credit != '0)) begin
              state <= S_WR;
            end else begin
              state <= S_WAIT;
              wcnt  <= '0;
            end
          end
          // DR reads stale right after an RB read; always settle before polling.
          S_RD: begin
            state <= S_WAIT;
            wcnt  <= '0;
          end
          S_WR: begin
            if (tx_ready_o) begin
              uart_we_o <= 1'b1; uart_addr_o <= A_RB; uart_dat_o <= tx_data_i;
              credit    <= credit - 1'b1;
              if (credit == CW'(1)) begin
                state <= S_WAIT;
                wcnt  <= '0;
              end
            end else begin
              state <= S_WAIT;
              wcnt  <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Directed bench for uart_host_ctrl: a small combinational uart_regs read
// model (LSR/RB), a bus access log, and a TX byte source advanced per cycle.
module tb_uart_host_ctrl;

  logic        clk = 1'b0;
  logic        wb_rst_ni;
  logic        cfg_start_i;
  logic [15:0] cfg_div_i;
  logic [6:0]  cfg_lcr_i;
  logic        cfg_done_o, cfg_err_o;
  logic [2:0]  uart_addr_o;
  logic [7:0]  uart_dat_o;
  logic        uart_we_o, uart_re_o;
  logic [7:0]  uart_dat_i;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i, tx_ready_o;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o, rx_ready_i;
  logic [4:0]  rx_err_o;

  logic [7:0]  lsr_val, rb_val;
  bit          dr_auto;

  typedef struct packed {
    int         cyc;
    logic       we;
    logic       re;
    logic [2:0] addr;
    logic [7:0] dat;
  } ev_t;

  ev_t        log_q[$];
  ev_t        wq[$];
  int         cyc, n_chk, n_fail, tx_idx, tx_n, k, g, rd_cyc;
  logic [7:0] tx_bytes [0:31];
  logic [12:0] exp_cfg [0:5];

  always #5 clk = ~clk;

  assign uart_dat_i = !uart_re_o ? 8'h00 :
                      (uart_addr_o == 3'd5) ? lsr_val :
                      (uart_addr_o == 3'd0) ? rb_val : 8'h00;

  uart_host_ctrl dut (
    .clk(clk), .wb_rst_ni(wb_rst_ni),
    .cfg_start_i(cfg_start_i), .cfg_div_i(cfg_div_i), .cfg_lcr_i(cfg_lcr_i),
    .cfg_done_o(cfg_done_o), .cfg_err_o(cfg_err_o),
    .uart_addr_o(uart_addr_o), .uart_dat_o(uart_dat_o),
    .uart_we_o(uart_we_o), .uart_re_o(uart_re_o), .uart_dat_i(uart_dat_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_err_o(rx_err_o)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Log this cycle's bus access at the falling edge, then advance one cycle.
  task automatic tick();
    bit hs, rd0;
    @(negedge clk);
    if (uart_we_o || uart_re_o)
      log_q.push_back('{cyc, uart_we_o, uart_re_o, uart_addr_o,
                        uart_we_o ? uart_dat_o : uart_dat_i});
    hs  = tx_valid_i && tx_ready_o;
    rd0 = uart_re_o && (uart_addr_o == 3'd0);
    @(posedge clk); #1;
    cyc++;
    if (hs) tx_idx++;
    if (rd0 && dr_auto) lsr_val[0] = 1'b0;
    tx_valid_i = (tx_idx < tx_n);
    tx_data_i  = tx_bytes[tx_idx[4:0]];
  endtask

  function automatic int cnt(logic we, logic [2:0] addr);
    int n = 0;
    foreach (log_q[i])
      if (log_q[i].we == we && log_q[i].re == !we && log_q[i].addr == addr) n++;
    return n;
  endfunction

  task automatic collect_writes();
    wq.delete();
    foreach (log_q[i]) if (log_q[i].we && log_q[i].addr == 3'd0) wq.push_back(log_q[i]);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; tx_idx = 0; tx_n = 0; dr_auto = 0;
    wb_rst_ni = 1'b0; cfg_start_i = 1'b0; cfg_div_i = '0; cfg_lcr_i = '0;
    tx_data_i = '0; tx_valid_i = 1'b0; rx_ready_i = 1'b0;
    lsr_val = 8'h00; rb_val = 8'h00;
    for (int i = 0; i < 32; i++) tx_bytes[i] = 8'h00;
    exp_cfg[0] = {1'b1, 1'b0, 3'd3, 8'h83};
    exp_cfg[1] = {1'b1, 1'b0, 3'd0, 8'h02};
    exp_cfg[2] = {1'b1, 1'b0, 3'd1, 8'h01};
    exp_cfg[3] = {1'b1, 1'b0, 3'd3, 8'h03};
    exp_cfg[4] = {1'b1, 1'b0, 3'd2, 8'hC6};
    exp_cfg[5] = {1'b1, 1'b0, 3'd1, 8'h00};

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("reset_bus", {uart_we_o, uart_re_o, uart_addr_o, uart_dat_o}, 0);
    chk("reset_status", {cfg_done_o, cfg_err_o, tx_ready_o, rx_valid_o, rx_err_o, rx_data_o}, 0);
    wb_rst_ni = 1'b1;
    repeat (5) tick();
    chk("idle_no_access", log_q.size(), 0);

    // Configuration sequence
    cfg_div_i = 16'h0102; cfg_lcr_i = 7'h03; cfg_start_i = 1'b1;
    log_q.delete(); k = cyc;
    tick(); cfg_start_i = 1'b0;
    repeat (5) tick();
    chk("cfg_done_early", cfg_done_o, 0);
    tick();
    chk("cfg_done", cfg_done_o, 1);
    chk("cfg_nwr", log_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("cfg_wr%0d", i),
          {log_q[i].we, log_q[i].re, log_q[i].addr, log_q[i].dat}, exp_cfg[i]);
      chk($sformatf("cfg_cyc%0d", i), log_q[i].cyc, k + 1 + i);
    end

    // TX burst: 20 bytes, one THRE grant covers 16
    for (int i = 0; i < 20; i++) tx_bytes[i] = 8'h10 + 8'(i);
    lsr_val = 8'h60; log_q.delete(); tx_n = 20;
    g = 0;
    while (cnt(1'b1, 3'd0) == 0 && g < 100) begin tick(); g++; end
    chk("tx_start_bound", (g < 100), 1);
    lsr_val = 8'h00;
    repeat (40) tick();
    collect_writes();
    chk("tx_burst_n", wq.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tx_dat%0d", i), wq[i].dat, 8'h10 + 8'(i));
      chk($sformatf("tx_cyc%0d", i), wq[i].cyc, wq[0].cyc + i);
    end
    rd_cyc = -1;
    foreach (log_q[i])
      if (rd_cyc < 0 && log_q[i].re && log_q[i].addr == 3'd5 && log_q[i].cyc > wq[15].cyc)
        rd_cyc = log_q[i].cyc;
    chk("tx_poll_after", (rd_cyc > 0), 1);
    chk("tx_settle_gap", ((rd_cyc - wq[15].cyc) >= 4), 1);
    chk("tx_idx16", tx_idx, 16);
    lsr_val = 8'h60; log_q.delete();
    repeat (30) tick();
    collect_writes();
    chk("tx_rest_n", wq.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("tx_rest%0d", i), wq[i].dat, 8'h20 + 8'(i));
    chk("tx_idx20", tx_idx, 20);
    lsr_val = 8'h00;

    // RX with stalled consumer
    rx_ready_i = 1'b0; rb_val = 8'h5A; dr_auto = 0; lsr_val = 8'h61; log_q.delete();
    g = 0;
    while (!rx_valid_o && g < 50) begin tick(); g++; end
    chk("rx_valid_bound", rx_valid_o, 1);
    chk("rx_data1", rx_data_o, 8'h5A);
    repeat (20) tick();
    chk("rx_blocked_reads", cnt(1'b0, 3'd0), 1);
    chk("rx_hold", {rx_valid_o, rx_data_o}, {1'b1, 8'h5A});
    rb_val = 8'hA5; rx_ready_i = 1'b1;
    tick(); rx_ready_i = 1'b0;
    chk("rx_consumed", rx_valid_o, 0);
    repeat (20) tick();
    chk("rx_data2", {rx_valid_o, rx_data_o}, {1'b1, 8'hA5});
    chk("rx_reads2", cnt(1'b0, 3'd0), 2);

    // Simultaneous DR and TX: RB read first, a poll, then the THR write
    rx_ready_i = 1'b1; lsr_val = 8'h00;
    repeat (10) tick();
    dr_auto = 1; rb_val = 8'h3C; tx_bytes[20] = 8'h77;
    log_q.delete(); lsr_val = 8'h61; tx_n = 21;
    repeat (25) tick();
    chk("sim_ev0", {log_q[0].we, log_q[0].re, log_q[0].addr, log_q[0].dat}, {2'b01, 3'd5, 8'h61});
    chk("sim_ev1", {log_q[1].we, log_q[1].re, log_q[1].addr, log_q[1].dat}, {2'b01, 3'd0, 8'h3C});
    chk("sim_ev2", {log_q[2].we, log_q[2].re, log_q[2].addr, log_q[2].dat}, {2'b01, 3'd5, 8'h60});
    chk("sim_ev3", {log_q[3].we, log_q[3].re, log_q[3].addr, log_q[3].dat}, {2'b10, 3'd0, 8'h77});
    chk("sim_rxdata", rx_data_o, 8'h3C);

    // Sticky line errors
    lsr_val = 8'h00;
    repeat (10) tick();
    chk("err_clean", rx_err_o, 5'b00000);
    lsr_val = 8'h8F;
    repeat (10) tick();
    chk("err_set", rx_err_o, 5'b10111);
    lsr_val = 8'h00;
    repeat (10) tick();
    chk("err_sticky", rx_err_o, 5'b10111);

    // Divisor 0 is rejected without touching the FSM
    log_q.delete(); cfg_div_i = 16'h0000; cfg_start_i = 1'b1;
    tick(); cfg_start_i = 1'b0;
    chk("rej_err", cfg_err_o, 1);
    repeat (10) tick();
    chk("rej_no_writes", cnt(1'b1, 3'd0) + cnt(1'b1, 3'd1) + cnt(1'b1, 3'd2) + cnt(1'b1, 3'd3), 0);
    chk("rej_done_kept", cfg_done_o, 1);
    chk("rej_err_kept", rx_err_o, 5'b10111);

    // Restart, then async reset during C_DLM
    cfg_div_i = 16'h0003; cfg_lcr_i = 7'h1B; cfg_start_i = 1'b1;
    tick(); cfg_start_i = 1'b0;
    chk("re_cfg_flags", {cfg_err_o, cfg_done_o, rx_err_o}, 0);
    chk("re_cfg_lcrd", {uart_we_o, uart_re_o, uart_addr_o, uart_dat_o}, {2'b10, 3'd3, 8'h9B});
    tick(); tick();
    chk("re_cfg_dlm", {uart_we_o, uart_re_o, uart_addr_o, uart_dat_o}, {2'b10, 3'd1, 8'h00});
    wb_rst_ni = 1'b0; #1;
    chk("rst_mid_bus", {uart_we_o, uart_re_o, uart_addr_o, uart_dat_o}, 0);
    chk("rst_mid_status", {cfg_done_o, cfg_err_o, tx_ready_o, rx_valid_o, rx_err_o, rx_data_o}, 0);
    @(posedge clk); #1;
    wb_rst_ni = 1'b1; log_q.delete();
    repeat (30) tick();
    chk("rst_no_access", log_q.size(), 0);
    chk("rst_not_done", cfg_done_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
